// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, request/response records and
// the arbiter's pointer states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef struct packed {
    logic [3:0]  cntrl;
    logic        inv;
    logic [31:0] srcA;
    logic [31:0] srcB;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        branch;
  } alu_rsp_t;

  typedef enum logic {
    PREF0 = 1'b0,
    PREF1 = 1'b1
  } ptr_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle 32-bit integer ALU. The branch flag is only produced by the
// compare-style ops (SUB = equality, SLT/SLTU = less-than) and is flipped by
// inv; every other op, including undefined codes, reports flag 0.
module alu
  import alu_pkg::*;
(
  input  alu_req_t i_req,
  output alu_rsp_t o_rsp
);

  logic [4:0]  w_shamt;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;

  assign w_shamt = i_req.srcB[4:0];
  assign w_lt_s  = $signed(i_req.srcA) < $signed(i_req.srcB);
  assign w_lt_u  = i_req.srcA < i_req.srcB;
  assign w_eq    = i_req.srcA == i_req.srcB;

  // Operation decode; undefined codes fall to zero result and zero flag.
  always_comb begin
    o_rsp = '0;
    case (i_req.cntrl)
      ALU_ADD:   o_rsp.result = i_req.srcA + i_req.srcB;
      ALU_SUB: begin
        o_rsp.result = i_req.srcA - i_req.srcB;
        o_rsp.branch = w_eq ^ i_req.inv;
      end
      ALU_SLL:   o_rsp.result = i_req.srcA << w_shamt;
      ALU_SLT: begin
        o_rsp.result = {31'd0, w_lt_s};
        o_rsp.branch = w_lt_s ^ i_req.inv;
      end
      ALU_SLTU: begin
        o_rsp.result = {31'd0, w_lt_u};
        o_rsp.branch = w_lt_u ^ i_req.inv;
      end
      ALU_XOR:   o_rsp.result = i_req.srcA ^ i_req.srcB;
      ALU_SRL:   o_rsp.result = i_req.srcA >> w_shamt;
      ALU_SRA:   o_rsp.result = 32'($signed(i_req.srcA) >>> w_shamt);
      ALU_OR:    o_rsp.result = i_req.srcA | i_req.srcB;
      ALU_AND:   o_rsp.result = i_req.srcA & i_req.srcB;
      ALU_PASSB: o_rsp.result = i_req.srcB;
      default:   o_rsp = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU. At most one request is
// granted per cycle; its result is registered into that requester's
// response slot, which holds until consumed.
//
// Pointer FSM (only consulted when FAIR=1 and both requesters are eligible):
//   state | meaning
//   PREF0 | requester 0 wins a tie (reset state)
//   PREF1 | requester 1 wins a tie
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  reqValid,
  output logic [1:0]  reqReady,
  input  logic [3:0]  reqCntrl0,
  input  logic [3:0]  reqCntrl1,
  input  logic        reqInv0,
  input  logic        reqInv1,
  input  logic [31:0] reqSrcA0,
  input  logic [31:0] reqSrcA1,
  input  logic [31:0] reqSrcB0,
  input  logic [31:0] reqSrcB1,
  output logic [1:0]  rspValid,
  input  logic [1:0]  rspReady,
  output logic [31:0] rspResult0,
  output logic [31:0] rspResult1,
  output logic        rspBranch0,
  output logic        rspBranch1
);

  ptr_state_t r_ptr;
  logic [1:0] r_rsp_valid;
  alu_rsp_t   r_rsp0;
  alu_rsp_t   r_rsp1;

  logic [1:0] w_free;
  logic [1:0] w_elig;
  logic       w_grant0;
  logic       w_grant1;
  alu_req_t   w_alu_req;
  alu_rsp_t   w_alu_rsp;

  // A slot being drained this cycle counts as free so it can refill with no
  // bubble. Nothing is granted while reset is high.
  assign w_free   = ~r_rsp_valid | rspReady;
  assign w_elig   = reqValid & w_free & {2{~reset}};
  assign w_grant0 = w_elig[0] & (~w_elig[1] | !FAIR | (r_ptr == PREF0));
  assign w_grant1 = w_elig[1] & ~w_grant0;
  assign reqReady = {w_grant1, w_grant0};

  // Operand mux: granted requester drives the ALU, otherwise ADD of zeros.
  always_comb begin
    w_alu_req = '0;
    if (w_grant0) begin
      w_alu_req.cntrl = reqCntrl0;
      w_alu_req.inv   = reqInv0;
      w_alu_req.srcA  = reqSrcA0;
      w_alu_req.srcB  = reqSrcB0;
    end else if (w_grant1) begin
      w_alu_req.cntrl = reqCntrl1;
      w_alu_req.inv   = reqInv1;
      w_alu_req.srcA  = reqSrcA1;
      w_alu_req.srcB  = reqSrcB1;
    end
  end

  alu u_alu (
    .i_req (w_alu_req),
    .o_rsp (w_alu_rsp)
  );

  // Round-robin pointer: favour the requester that was not just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= PREF0;
    end else begin
      case (r_ptr)
        PREF0:   if (w_grant0) r_ptr <= PREF1;
        PREF1:   if (w_grant1) r_ptr <= PREF0;
        default: r_ptr <= PREF0;
      endcase
    end
  end

  // Response slots: capture on grant, clear on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 2'b00;
      r_rsp0      <= '0;
      r_rsp1      <= '0;
    end else begin
      if (w_grant0) begin
        r_rsp_valid[0] <= 1'b1;
        r_rsp0         <= w_alu_rsp;
      end else if (rspReady[0]) begin
        r_rsp_valid[0] <= 1'b0;
      end
      if (w_grant1) begin
        r_rsp_valid[1] <= 1'b1;
        r_rsp1         <= w_alu_rsp;
      end else if (rspReady[1]) begin
        r_rsp_valid[1] <= 1'b0;
      end
    end
  end

  assign rspValid   = r_rsp_valid;
  assign rspResult0 = r_rsp0.result;
  assign rspResult1 = r_rsp1.result;
  assign rspBranch0 = r_rsp0.branch;
  assign rspBranch1 = r_rsp1.branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  reqValid;
  logic [3:0]  reqCntrl0, reqCntrl1;
  logic        reqInv0, reqInv1;
  logic [31:0] reqSrcA0, reqSrcA1, reqSrcB0, reqSrcB1;
  logic [1:0]  rspReady;

  logic [1:0]  rr_reqReady, rr_rspValid;
  logic [31:0] rr_rspResult0, rr_rspResult1;
  logic        rr_rspBranch0, rr_rspBranch1;

  logic [1:0]  fp_reqReady, fp_rspValid;
  logic [31:0] fp_rspResult0, fp_rspResult1;
  logic        fp_rspBranch0, fp_rspBranch1;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(rr_reqReady),
    .reqCntrl0(reqCntrl0), .reqCntrl1(reqCntrl1), .reqInv0(reqInv0), .reqInv1(reqInv1),
    .reqSrcA0(reqSrcA0), .reqSrcA1(reqSrcA1), .reqSrcB0(reqSrcB0), .reqSrcB1(reqSrcB1),
    .rspValid(rr_rspValid), .rspReady(rspReady),
    .rspResult0(rr_rspResult0), .rspResult1(rr_rspResult1),
    .rspBranch0(rr_rspBranch0), .rspBranch1(rr_rspBranch1)
  );

  alu_arbiter #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(fp_reqReady),
    .reqCntrl0(reqCntrl0), .reqCntrl1(reqCntrl1), .reqInv0(reqInv0), .reqInv1(reqInv1),
    .reqSrcA0(reqSrcA0), .reqSrcA1(reqSrcA1), .reqSrcB0(reqSrcB0), .reqSrcB1(reqSrcB1),
    .rspValid(fp_rspValid), .rspReady(rspReady),
    .rspResult0(fp_rspResult0), .rspResult1(fp_rspResult1),
    .rspBranch0(fp_rspBranch0), .rspBranch1(fp_rspBranch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    reqValid = 2'b00;
    rspReady = 2'b00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // reset is already high from time 0; requests must not be granted
    reqValid  = 2'b11;
    reqCntrl0 = 4'b0000; reqSrcA0 = 32'd1; reqSrcB0 = 32'd1; reqInv0 = 1'b0;
    reqCntrl1 = 4'b0000; reqSrcA1 = 32'd2; reqSrcB1 = 32'd2; reqInv1 = 1'b0;
    @(negedge clk);
    tests++;
    if (rr_reqReady !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b want 00", rr_reqReady);
    end
    tests++;
    if (fp_reqReady !== 2'b00) begin
      fails++; $display("FAIL reset_ready_fp: got %b want 00", fp_reqReady);
    end
    @(negedge clk);
    tests++;
    if (rr_rspValid !== 2'b00) begin
      fails++; $display("FAIL reset_rspValid: got %b want 00", rr_rspValid);
    end
    tests++;
    if ({rr_rspResult0, rr_rspResult1, rr_rspBranch0, rr_rspBranch1} !== 66'd0) begin
      fails++; $display("FAIL reset_data: got %h %h %b %b want zeros",
                        rr_rspResult0, rr_rspResult1, rr_rspBranch0, rr_rspBranch1);
    end
    reqValid = 2'b00;
    reset    = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    reqCntrl0 = 4'b0000; reqSrcA0 = 32'd5; reqSrcB0 = 32'd7; reqInv0 = 1'b0;
    reqValid  = 2'b01;
    rspReady  = 2'b11;
    #1;
    tests++;
    if (rr_reqReady !== 2'b01) begin
      fails++; $display("FAIL single_ready: got %b want 01", rr_reqReady);
    end
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    tests++;
    if (rr_rspValid !== 2'b01 || rr_rspResult0 !== 32'd12 || rr_rspBranch0 !== 1'b0) begin
      fails++; $display("FAIL single_rsp: got v=%b r=%0d b=%b want v=01 r=12 b=0",
                        rr_rspValid, rr_rspResult0, rr_rspBranch0);
    end
    tests++;
    if (rr_reqReady !== 2'b00) begin
      fails++; $display("FAIL single_idle_ready: got %b want 00", rr_reqReady);
    end
  endtask

  task automatic set_contention_ops();
    reqCntrl0 = 4'b1000; reqSrcA0 = 32'd10;         reqSrcB0 = 32'd10; reqInv0 = 1'b0;
    reqCntrl1 = 4'b0010; reqSrcA1 = 32'hFFFF_FFFF;  reqSrcB1 = 32'd1;  reqInv1 = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] exp_ready;
    do_reset();
    set_contention_ops();
    rspReady = 2'b11;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) reqValid = 2'b11; else reqValid = 2'b00;
      #1;
      if (k > 0) begin
        if (((k - 1) % 2) == 0) begin
          tests++;
          if (rr_rspValid !== 2'b01 || rr_rspResult0 !== 32'd0 || rr_rspBranch0 !== 1'b1) begin
            fails++; $display("FAIL rr_rsp0 k=%0d: got v=%b r=%h b=%b want v=01 r=0 b=1",
                              k, rr_rspValid, rr_rspResult0, rr_rspBranch0);
          end
        end else begin
          tests++;
          if (rr_rspValid !== 2'b10 || rr_rspResult1 !== 32'd1 || rr_rspBranch1 !== 1'b1) begin
            fails++; $display("FAIL rr_rsp1 k=%0d: got v=%b r=%h b=%b want v=10 r=1 b=1",
                              k, rr_rspValid, rr_rspResult1, rr_rspBranch1);
          end
        end
      end
      if (k < 4) begin
        exp_ready = ((k % 2) == 0) ? 2'b01 : 2'b10;
        tests++;
        if (rr_reqReady !== exp_ready) begin
          fails++; $display("FAIL rr_grant k=%0d: got %b want %b", k, rr_reqReady, exp_ready);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_contention_ops();
    rspReady = 2'b11;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) reqValid = 2'b11; else reqValid = 2'b00;
      #1;
      if (k > 0) begin
        tests++;
        if (fp_rspValid !== 2'b01 || fp_rspResult0 !== 32'd0 || fp_rspBranch0 !== 1'b1) begin
          fails++; $display("FAIL fp_rsp k=%0d: got v=%b r=%h b=%b want v=01 r=0 b=1",
                            k, fp_rspValid, fp_rspResult0, fp_rspBranch0);
        end
      end
      if (k < 4) begin
        tests++;
        if (fp_reqReady !== 2'b01) begin
          fails++; $display("FAIL fp_grant k=%0d: got %b want 01", k, fp_reqReady);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    reqCntrl0 = 4'b0000; reqSrcA0 = 32'd1; reqSrcB0 = 32'd2; reqInv0 = 1'b0;
    reqValid  = 2'b01;
    rspReady  = 2'b00;
    #1;
    tests++;
    if (rr_reqReady !== 2'b01) begin
      fails++; $display("FAIL bp_first_grant: got %b want 01", rr_reqReady);
    end
    // slot 0 now full and stalled; req0 presents its next op (SRA)
    @(negedge clk);
    reqCntrl0 = 4'b1101; reqSrcA0 = 32'h8000_0000; reqSrcB0 = 32'd4;
    reqCntrl1 = 4'b0100; reqSrcA1 = 32'h0000_00F0; reqSrcB1 = 32'h0000_000F; reqInv1 = 1'b0;
    reqValid  = 2'b11;
    rspReady  = 2'b10;
    #1;
    tests++;
    if (rr_rspValid !== 2'b01 || rr_rspResult0 !== 32'd3) begin
      fails++; $display("FAIL bp_slot0_fill: got v=%b r=%0d want v=01 r=3", rr_rspValid, rr_rspResult0);
    end
    tests++;
    if (rr_reqReady !== 2'b10) begin
      fails++; $display("FAIL bp_other_wins: got %b want 10", rr_reqReady);
    end
    @(negedge clk);
    reqValid = 2'b01;
    #1;
    tests++;
    if (rr_rspValid !== 2'b11 || rr_rspResult0 !== 32'd3 || rr_rspResult1 !== 32'h0000_00FF) begin
      fails++; $display("FAIL bp_hold: got v=%b r0=%h r1=%h want v=11 r0=3 r1=ff",
                        rr_rspValid, rr_rspResult0, rr_rspResult1);
    end
    tests++;
    if (rr_reqReady !== 2'b00) begin
      fails++; $display("FAIL bp_blocked: got %b want 00", rr_reqReady);
    end
    @(negedge clk);
    rspReady = 2'b01;
    #1;
    tests++;
    if (rr_rspValid !== 2'b01 || rr_rspResult0 !== 32'd3) begin
      fails++; $display("FAIL bp_still_held: got v=%b r=%h want v=01 r=3", rr_rspValid, rr_rspResult0);
    end
    tests++;
    if (rr_reqReady !== 2'b01) begin
      fails++; $display("FAIL bp_drain_refill_grant: got %b want 01", rr_reqReady);
    end
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    tests++;
    if (rr_rspValid !== 2'b01 || rr_rspResult0 !== 32'hF800_0000 || rr_rspBranch0 !== 1'b0) begin
      fails++; $display("FAIL bp_refill_data: got v=%b r=%h b=%b want v=01 r=f8000000 b=0",
                        rr_rspValid, rr_rspResult0, rr_rspBranch0);
    end
    rspReady = 2'b11;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    reqCntrl0 = 4'b0000; reqSrcA0 = 32'd5; reqSrcB0 = 32'd7; reqInv0 = 1'b0;
    reqCntrl1 = 4'b0000; reqSrcA1 = 32'd1; reqSrcB1 = 32'd1; reqInv1 = 1'b0;
    reqValid  = 2'b01;
    rspReady  = 2'b00;
    #1;
    tests++;
    if (rr_reqReady !== 2'b01) begin
      fails++; $display("FAIL rm_grant: got %b want 01", rr_reqReady);
    end
    @(negedge clk);
    reset    = 1'b1;
    reqValid = 2'b10;
    #1;
    tests++;
    if (rr_reqReady !== 2'b00) begin
      fails++; $display("FAIL rm_no_grant_in_reset: got %b want 00", rr_reqReady);
    end
    @(negedge clk);
    reset    = 1'b0;
    reqValid = 2'b11;
    rspReady = 2'b11;
    #1;
    tests++;
    if (rr_rspValid !== 2'b00 || rr_rspResult0 !== 32'd0) begin
      fails++; $display("FAIL rm_cleared: got v=%b r=%0d want v=00 r=0", rr_rspValid, rr_rspResult0);
    end
    tests++;
    if (rr_reqReady !== 2'b01) begin
      fails++; $display("FAIL rm_ptr_pref0: got %b want 01", rr_reqReady);
    end
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    tests++;
    if (rr_rspValid !== 2'b01 || rr_rspResult0 !== 32'd12) begin
      fails++; $display("FAIL rm_post_rsp: got v=%b r=%0d want v=01 r=12", rr_rspValid, rr_rspResult0);
    end
  endtask

  task automatic test_undefined();
    @(negedge clk);
    reqCntrl1 = 4'b1010; reqSrcA1 = 32'd123; reqSrcB1 = 32'd45; reqInv1 = 1'b0;
    reqValid  = 2'b10;
    rspReady  = 2'b11;
    #1;
    tests++;
    if (rr_reqReady !== 2'b10) begin
      fails++; $display("FAIL undef_grant: got %b want 10", rr_reqReady);
    end
    @(negedge clk);
    reqValid = 2'b00;
    #1;
    tests++;
    if (rr_rspValid[1] !== 1'b1 || rr_rspResult1 !== 32'd0 || rr_rspBranch1 !== 1'b0) begin
      fails++; $display("FAIL undef_rsp: got v=%b r=%h b=%b want v1=1 r=0 b=0",
                        rr_rspValid, rr_rspResult1, rr_rspBranch1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  v_op  [5];
    logic [31:0] v_a   [5];
    logic [31:0] v_b   [5];
    logic        v_inv [5];
    logic [31:0] v_res [5];
    logic        v_br  [5];
    v_op[0] = 4'b0000; v_a[0] = 32'hFFFF_FFFF; v_b[0] = 32'd2;         v_inv[0] = 1'b0; v_res[0] = 32'd1;         v_br[0] = 1'b0;
    v_op[1] = 4'b0011; v_a[1] = 32'd1;         v_b[1] = 32'hFFFF_FFFF; v_inv[1] = 1'b0; v_res[1] = 32'd1;         v_br[1] = 1'b1;
    v_op[2] = 4'b0001; v_a[2] = 32'd1;         v_b[2] = 32'd31;        v_inv[2] = 1'b0; v_res[2] = 32'h8000_0000; v_br[2] = 1'b0;
    v_op[3] = 4'b1000; v_a[3] = 32'd5;         v_b[3] = 32'd3;         v_inv[3] = 1'b1; v_res[3] = 32'd2;         v_br[3] = 1'b1;
    v_op[4] = 4'b1111; v_a[4] = 32'd0;         v_b[4] = 32'h0000_ABCD; v_inv[4] = 1'b0; v_res[4] = 32'h0000_ABCD; v_br[4] = 1'b0;
    rspReady = 2'b01;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        reqCntrl0 = v_op[k]; reqSrcA0 = v_a[k]; reqSrcB0 = v_b[k]; reqInv0 = v_inv[k];
        reqValid  = 2'b01;
      end else begin
        reqValid = 2'b00;
      end
      #1;
      if (k > 0) begin
        tests++;
        if (rr_rspValid[0] !== 1'b1 || rr_rspResult0 !== v_res[k-1] || rr_rspBranch0 !== v_br[k-1]) begin
          fails++; $display("FAIL b2b_rsp k=%0d: got v=%b r=%h b=%b want v0=1 r=%h b=%b",
                            k, rr_rspValid, rr_rspResult0, rr_rspBranch0, v_res[k-1], v_br[k-1]);
        end
      end
      if (k < 5) begin
        tests++;
        if (rr_reqReady !== 2'b01) begin
          fails++; $display("FAIL b2b_grant k=%0d: got %b want 01", k, rr_reqReady);
        end
      end
    end
    rspReady = 2'b11;
  endtask

  initial begin
    reset     = 1'b1;
    reqValid  = 2'b00;
    rspReady  = 2'b00;
    reqCntrl0 = '0; reqCntrl1 = '0;
    reqInv0   = 1'b0; reqInv1 = 1'b0;
    reqSrcA0  = '0; reqSrcA1 = '0; reqSrcB0 = '0; reqSrcB1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_fixed_priority();
    test_backpressure();
    test_reset_mid();
    test_undefined();
    test_back_to_back();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer `alu` between two requesters, e.g. the execute stage and the address/branch-compare unit, through valid/ready handshakes. Each cycle it grants at most one request. A round-robin or fixed-priority pointer picks the winner. The granted operands drive one `alu` instance, and the result and branch flag are registered into a per-requester response slot. Each slot holds its response until that requester consumes it.

## Interface
- `FAIR`, default 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `reqValid[1:0]`  in  2  request i carries a valid operation.
- `reqReady[1:0]`  out  2  request i is granted this cycle (combinational).
- `reqCntrl0`, `reqCntrl1`  in  4 each  ALU operation code for requester 0/1.
- `reqInv0`, `reqInv1`  in  1 each  branch-flag inversion.
- `reqSrcA0`, `reqSrcA1`, `reqSrcB0`, `reqSrcB1`  in  32 each  operands.
- `rspValid[1:0]`  out  2  slot i holds a result.
- `rspReady[1:0]`  in  2  requester i consumes slot i.
- `rspResult0`, `rspResult1`  out  32 each  registered ALU result.
- `rspBranch0`, `rspBranch1`  out  1 each  registered branch flag.

## Operation
- **Slot free:** slot i is free when `!rspValid[i] || rspReady[i]`. A slot being drained this cycle is free, so it can be refilled in the same cycle.
- **Eligible:** requester i is eligible when `reqValid[i] && free_i`.
- **Grant rules:**
  - Only one eligible requester: it is granted.
  - Both eligible, FAIR=1: the requester the pointer favours is granted.
  - Both eligible, FAIR=0: requester 0 is granted.
  - Neither eligible: no grant.
- **Ready:** `reqReady[i] = grant_i`. Handshake happens when valid && ready. Requesters must hold operands stable while valid && !ready and must not make valid depend on ready.
- **ALU drive:** the ALU input mux selects the granted requester's cntrl/inv/srcA/srcB. With no grant it drives cntrl=4'b0000 and zeros; the result is discarded.
- **Pointer (2-state FSM):**
  - States: PREF0 and PREF1; reset state is PREF0.
  - A grant to 0 moves it to PREF1; a grant to 1 moves it to PREF0.
  - No grant leaves it unchanged.
  - The pointer is unused when FAIR=0.
- **Slot capture:** on grant to i, the next cycle gives `rspValid[i]=1`, `rspResult_i=aluResult`, `rspBranch_i=branchFlag`.
- **Slot hold:** the slot is held stable while `rspValid[i] && !rspReady[i]`.
- **Slot clear:** on drain without refill, `rspValid[i]` goes to 0; the data may stay stale.
- **Codes:** undefined aluCntrl codes pass through unchanged; the ALU returns result 0 and flag 0, delivered as a normal response. Width is fixed at 32 bits with no saturation; wrap-around is the ALU's.

## Timing
- **Reset values:** `rspValid=0`, `rspResult*=0`, `rspBranch*=0`, pointer=PREF0. `reqReady=0` whenever `reqValid=0`.
- **Latency:** one cycle from handshake to `rspValid`.
- **Throughput:** one operation per cycle in aggregate. A single requester with `rspReady` held high gets one operation per cycle back-to-back.
- **Simultaneous events:** drain and refill of the same slot in one cycle is a legal update; the new result replaces the old one with no bubble.
- **Backpressure:** a requester whose slot is full and not draining is not granted, and the other requester takes the ALU that cycle.
- **Reset mid-operation:** pending slots are cleared without delivery, the pointer returns to PREF0, and no grant is issued in a cycle where `reset=1`.
- **Starvation bound (FAIR=1):** a continuously eligible requester waits at most one cycle.

## Structure
- Shared package `alu_pkg`:
  - `localparam` codes ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL=4'b0001, ALU_SLT=4'b0010, ALU_SLTU=4'b0011, ALU_XOR=4'b0100, ALU_SRL=4'b0101, ALU_SRA=4'b1101, ALU_OR=4'b0110, ALU_AND=4'b0111, ALU_PASSB=4'b1111.
  - Typedef `alu_req_t` {cntrl, inv, srcA, srcB} and typedef `alu_rsp_t` {result, branch}.
- Exactly one sub-module: the existing `alu`, instantiated once. Grant logic, pointer and slots stay inline.

## Test plan
- **Single request:** reset released; req0 ADD 5+7 with `rspReady0=1` -> `reqReady0=1` the same cycle, next cycle `rspValid0=1` and `rspResult0=12`.
- **Contention, FAIR=1:** both requests held valid for 4 cycles (req0 SUB 10-10 inv=0, req1 SLT -1<1) -> grants 0,1,0,1. Responses are `rspResult0=0, rspBranch0=1` and `rspResult1=1, rspBranch1=1`.
- **Fixed priority, FAIR=0:** same stimulus -> req0 granted every cycle and req1 never granted while req0 stays valid.
- **Backpressure:**
  - `rspReady0=0` with slot 0 full, both valid: req1 is granted and slot 0 holds its value unchanged.
  - Raise `rspReady0` with req0 still valid: same-cycle drain and refill with a new SRA 0x80000000>>>4 -> next result 0xF8000000.
- **Reset mid-operation:** assert `reset` in the cycle after a grant -> `rspValid=2'b00` the next cycle, no response is delivered, and the first post-reset contention grants requester 0.
- **Undefined code:** req1 cntrl=4'b1010 -> `rspValid1=1`, `rspResult1=0`, `rspBranch1=0`.
